// File: rtl/vebpf_multi_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module   : vebpf_multi_dispatcher_if
// Purpose  : Requester and core-side bundle of the multi-requester vEBPF
//            dispatcher. The dispatcher uses the slave view.
// Revision : 1.0 - initial release
// ============================================================================
interface vebpf_multi_dispatcher_if #(
    parameter int NUM_REQ           = 4,
    parameter int NUM_CORE          = 2,
    parameter int FUNCTION_ID_WIDTH = 8,
    parameter int REG_WIDTH         = 64
);
    logic [NUM_REQ-1:0]                     req_valid;
    logic [NUM_REQ-1:0]                     req_ready;
    logic [NUM_REQ*FUNCTION_ID_WIDTH-1:0]   req_fid;
    logic [NUM_REQ*3*REG_WIDTH-1:0]         req_args;
    logic [NUM_REQ-1:0]                     resp_valid;
    logic [NUM_REQ-1:0]                     resp_timeout;
    logic [NUM_REQ*REG_WIDTH-1:0]           resp_r0;
    logic [NUM_CORE-1:0]                    core_start;
    logic [NUM_CORE*FUNCTION_ID_WIDTH-1:0]  core_fid;
    logic [NUM_CORE*3*REG_WIDTH-1:0]        core_args;
    logic [NUM_CORE-1:0]                    core_abort;
    logic [NUM_CORE-1:0]                    core_done;
    logic [NUM_CORE*REG_WIDTH-1:0]          core_r0;

    modport master (
        output req_valid, req_fid, req_args, core_done, core_r0,
        input  req_ready, resp_valid, resp_timeout, resp_r0,
               core_start, core_fid, core_args, core_abort
    );

    modport slave (
        input  req_valid, req_fid, req_args, core_done, core_r0,
        output req_ready, resp_valid, resp_timeout, resp_r0,
               core_start, core_fid, core_args, core_abort
    );
endinterface
`default_nettype wire

// File: rtl/vebpf_multi_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : vebpf_multi_dispatcher
// Purpose  : Round-robin dispatch of helper calls from NUM_REQ requesters onto
//            NUM_CORE vEBPF cores, with owner tracking and per-core watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module vebpf_multi_dispatcher #(
    parameter int NUM_REQ           = 4,
    parameter int NUM_CORE          = 2,
    parameter int FUNCTION_ID_WIDTH = 8,
    parameter int REG_WIDTH         = 64,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  wire logic               clk,
    input  wire logic               rst,
    vebpf_multi_dispatcher_if.slave bus
);
    localparam int c_RIW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CIW  = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
    localparam int c_WDW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int c_FW   = FUNCTION_ID_WIDTH;
    localparam int c_AW   = 3 * REG_WIDTH;
    localparam logic [c_WDW-1:0] c_WD_LIMIT = c_WDW'(TIMEOUT_CYCLES - 1);
    localparam bit   c_WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [NUM_CORE-1:0]         r_state;
    logic [NUM_CORE-1:0]         w_state_nxt;
    logic [c_RIW-1:0]            r_owner [NUM_CORE];
    logic [c_WDW-1:0]            r_wdog  [NUM_CORE];
    logic [NUM_REQ-1:0]          r_outstanding;
    logic [c_RIW-1:0]            r_rr_ptr;

    logic [NUM_REQ-1:0]          r_resp_valid;
    logic [NUM_REQ-1:0]          r_resp_timeout;
    logic [NUM_REQ*REG_WIDTH-1:0] r_resp_r0;
    logic [NUM_CORE-1:0]         r_core_start;
    logic [NUM_CORE-1:0]         r_core_abort;
    logic [NUM_CORE*c_FW-1:0]    r_core_fid;
    logic [NUM_CORE*c_AW-1:0]    r_core_args;

    logic [NUM_REQ-1:0]          w_eligible;
    logic [NUM_REQ-1:0]          w_grant;
    logic                        w_grant_vld;
    logic [c_RIW-1:0]            w_grant_idx;
    logic [c_RIW-1:0]            w_scan;
    logic                        w_any_idle;
    logic [c_CIW-1:0]            w_tgt;
    logic [NUM_CORE-1:0]         w_launch;
    logic [NUM_CORE-1:0]         w_done_ev;
    logic [NUM_CORE-1:0]         w_expire;

    // Arbitration: lowest idle core is the target, requesters scanned from rr_ptr.
    always_comb begin
        w_any_idle = 1'b0;
        w_tgt      = '0;
        for (int c = NUM_CORE - 1; c >= 0; c--) begin
            if (r_state[c] == c_IDLE) begin
                w_any_idle = 1'b1;
                w_tgt      = c_CIW'(c);
            end
        end
        w_eligible  = bus.req_valid & ~r_outstanding;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = ((int'(r_rr_ptr) + k) >= NUM_REQ) ? c_RIW'(int'(r_rr_ptr) + k - NUM_REQ)
                                                       : c_RIW'(int'(r_rr_ptr) + k);
            if (w_any_idle && !w_grant_vld && w_eligible[w_scan]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_scan;
            end
        end
        w_grant = '0;
        if (w_grant_vld) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        for (int c = 0; c < NUM_CORE; c++) begin
            case (r_state[c])
                c_IDLE:  if (w_launch[c]) w_state_nxt[c] = c_BUSY;
                c_BUSY:  if (w_done_ev[c] || w_expire[c]) w_state_nxt[c] = c_IDLE;
                default: w_state_nxt[c] = c_IDLE;
            endcase
        end
    end

    // Done takes priority over a watchdog expiry in the same cycle.
    always_comb begin
        w_launch  = '0;
        w_done_ev = '0;
        w_expire  = '0;
        for (int c = 0; c < NUM_CORE; c++) begin
            w_launch[c]  = w_grant_vld && (w_tgt == c_CIW'(c)) && (r_state[c] == c_IDLE);
            w_done_ev[c] = (r_state[c] == c_BUSY) && bus.core_done[c];
            w_expire[c]  = c_WD_EN && (r_state[c] == c_BUSY) && !bus.core_done[c]
                           && (r_wdog[c] == c_WD_LIMIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding  <= '0;
            r_rr_ptr       <= '0;
            r_resp_valid   <= '0;
            r_resp_timeout <= '0;
            r_resp_r0      <= '0;
            r_core_start   <= '0;
            r_core_abort   <= '0;
            r_core_fid     <= '0;
            r_core_args    <= '0;
            for (int c = 0; c < NUM_CORE; c++) begin
                r_owner[c] <= '0;
                r_wdog[c]  <= '0;
            end
        end else begin
            r_core_start   <= w_launch;
            r_core_abort   <= w_expire;
            r_resp_valid   <= '0;
            r_resp_timeout <= '0;
            if (w_grant_vld) begin
                r_outstanding[w_grant_idx] <= 1'b1;
                r_rr_ptr <= (w_grant_idx == c_RIW'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
            end
            for (int c = 0; c < NUM_CORE; c++) begin
                if (w_launch[c]) begin
                    r_core_fid[c*c_FW +: c_FW]  <= bus.req_fid[w_grant_idx*c_FW +: c_FW];
                    r_core_args[c*c_AW +: c_AW] <= bus.req_args[w_grant_idx*c_AW +: c_AW];
                    r_owner[c] <= w_grant_idx;
                    r_wdog[c]  <= '0;
                end else if (r_state[c] == c_BUSY) begin
                    r_wdog[c] <= r_wdog[c] + 1'b1;
                end
                // Owners of busy cores are distinct, so these writes never collide.
                if (w_done_ev[c]) begin
                    r_resp_valid[r_owner[c]] <= 1'b1;
                    r_resp_r0[r_owner[c]*REG_WIDTH +: REG_WIDTH] <= bus.core_r0[c*REG_WIDTH +: REG_WIDTH];
                    r_outstanding[r_owner[c]] <= 1'b0;
                end else if (w_expire[c]) begin
                    r_resp_valid[r_owner[c]]   <= 1'b1;
                    r_resp_timeout[r_owner[c]] <= 1'b1;
                    r_resp_r0[r_owner[c]*REG_WIDTH +: REG_WIDTH] <= '0;
                    r_outstanding[r_owner[c]] <= 1'b0;
                end
            end
        end
    end

    assign bus.req_ready    = w_grant;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_timeout = r_resp_timeout;
    assign bus.resp_r0      = r_resp_r0;
    assign bus.core_start   = r_core_start;
    assign bus.core_abort   = r_core_abort;
    assign bus.core_fid     = r_core_fid;
    assign bus.core_args    = r_core_args;
endmodule
`default_nettype wire

// File: tb/tb_vebpf_multi_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_vebpf_multi_dispatcher
// Purpose  : Directed scoreboard bench for vebpf_multi_dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vebpf_multi_dispatcher;
    localparam int NREQ = 4;
    localparam int NCORE = 2;
    localparam int FW = 8;
    localparam int RW = 64;
    localparam int AW = 3 * RW;
    localparam int TO = 16;

    typedef struct { int idx; logic to; logic [RW-1:0] r0; int cyc; } resp_t;
    typedef struct { int core; logic [FW-1:0] fid; logic [AW-1:0] args; int cyc; } start_t;
    typedef struct { int core; int cyc; } abort_t;

    logic clk = 1'b0;
    logic rst;
    logic mon_en = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   rpos, spos, apos;

    resp_t  resp_q[$];
    start_t start_q[$];
    abort_t abort_q[$];
    logic [FW-1:0] drv_fid  [NREQ];
    logic [AW-1:0] drv_args [NREQ];

    vebpf_multi_dispatcher_if #(.NUM_REQ(NREQ), .NUM_CORE(NCORE),
        .FUNCTION_ID_WIDTH(FW), .REG_WIDTH(RW)) bus ();

    vebpf_multi_dispatcher #(.NUM_REQ(NREQ), .NUM_CORE(NCORE), .FUNCTION_ID_WIDTH(FW),
        .REG_WIDTH(RW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    // Scoreboard monitor: every response, launch and abort must match a queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.resp_valid[i]) begin
                    rpos = -1;
                    for (int k = 0; k < resp_q.size(); k++)
                        if (rpos < 0 && resp_q[k].idx == i) rpos = k;
                    if (rpos < 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_resp req=%0d cyc=%0d actual=1 required=0", i, cyc);
                    end else begin
                        chk("resp_timeout", bus.resp_timeout[i], resp_q[rpos].to);
                        chk("resp_r0", bus.resp_r0[i*RW +: RW], resp_q[rpos].r0);
                        chk("resp_cycle", cyc, resp_q[rpos].cyc);
                        resp_q.delete(rpos);
                    end
                end
            end
            for (int c = 0; c < NCORE; c++) begin
                if (bus.core_start[c]) begin
                    spos = -1;
                    for (int k = 0; k < start_q.size(); k++)
                        if (spos < 0 && start_q[k].core == c) spos = k;
                    if (spos < 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_start core=%0d cyc=%0d actual=1 required=0", c, cyc);
                    end else begin
                        chk("start_fid", bus.core_fid[c*FW +: FW], start_q[spos].fid);
                        chk("start_args", bus.core_args[c*AW +: AW], start_q[spos].args);
                        chk("start_cycle", cyc, start_q[spos].cyc);
                        start_q.delete(spos);
                    end
                end
                if (bus.core_abort[c]) begin
                    apos = -1;
                    for (int k = 0; k < abort_q.size(); k++)
                        if (apos < 0 && abort_q[k].core == c) apos = k;
                    if (apos < 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_abort core=%0d cyc=%0d actual=1 required=0", c, cyc);
                    end else begin
                        chk("abort_cycle", cyc, abort_q[apos].cyc);
                        abort_q.delete(apos);
                    end
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req_on(input int i, input logic [FW-1:0] fid,
                          input logic [RW-1:0] r1, input logic [RW-1:0] r2, input logic [RW-1:0] r3);
        drv_fid[i]  = fid;
        drv_args[i] = {r3, r2, r1};
        bus.req_fid[i*FW +: FW]  = fid;
        bus.req_args[i*AW +: AW] = {r3, r2, r1};
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic req_off(input int i);
        bus.req_valid[i] = 1'b0;
    endtask

    // Checks req_ready this cycle; a grant implies a launch on the given core next cycle.
    task automatic grant_step(input string nm, input logic [NREQ-1:0] exp, input int core, input int req);
        @(negedge clk);
        chk(nm, bus.req_ready, exp);
        if (exp != '0) start_q.push_back('{core, drv_fid[req], drv_args[req], cyc + 1});
        @(posedge clk);
        #1;
    endtask

    task automatic done(input int c, input logic [RW-1:0] r0);
        bus.core_done[c] = 1'b1;
        bus.core_r0[c*RW +: RW] = r0;
    endtask

    task automatic expect_resp(input int i, input logic to, input logic [RW-1:0] r0, input int at);
        resp_q.push_back('{i, to, r0, at});
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_fid   = '0;
        bus.req_args  = '0;
        bus.core_done = '0;
        bus.core_r0   = '0;
        for (int i = 0; i < NREQ; i++) begin
            drv_fid[i] = '0;
            drv_args[i] = '0;
        end
        tick(3);
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_timeout", bus.resp_timeout, 0);
        chk("rst_resp_r0", bus.resp_r0, 0);
        chk("rst_core_start", bus.core_start, 0);
        chk("rst_core_abort", bus.core_abort, 0);
        chk("rst_core_fid", bus.core_fid, 0);
        chk("rst_core_args", bus.core_args, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Single request, done in the launch cycle.
        req_on(0, 8'h01, 64'd4, 64'h2222, 64'h3333);
        grant_step("single_grant", 4'b0001, 0, 0);
        req_off(0);
        done(0, 64'h10);
        expect_resp(0, 1'b0, 64'h10, cyc + 1);
        tick();
        bus.core_done = '0;
        tick(2);

        // Contention: restart round-robin from requester 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) req_on(i, 8'(8'h20 + i), 64'(100 + i), 64'(200 + i), 64'(300 + i));
        grant_step("cont_g0", 4'b0001, 0, 0);
        req_off(0);
        grant_step("cont_g1", 4'b0010, 1, 1);
        req_off(1);
        grant_step("cont_full0", 4'b0000, 0, 0);
        grant_step("cont_full1", 4'b0000, 0, 0);
        done(1, 64'hB1);
        expect_resp(1, 1'b0, 64'hB1, cyc + 1);
        grant_step("cont_done_cyc", 4'b0000, 0, 0);
        bus.core_done = '0;
        grant_step("cont_g2", 4'b0100, 1, 2);
        req_off(2);
        done(0, 64'hA0);
        expect_resp(0, 1'b0, 64'hA0, cyc + 1);
        grant_step("cont_busy", 4'b0000, 0, 0);
        bus.core_done = '0;
        grant_step("cont_g3", 4'b1000, 0, 3);
        req_off(3);
        done(0, 64'hA3);
        done(1, 64'hA2);
        expect_resp(3, 1'b0, 64'hA3, cyc + 1);
        expect_resp(2, 1'b0, 64'hA2, cyc + 1);
        tick();
        bus.core_done = '0;
        tick();

        // Round-robin between requesters 1 and 3.
        req_on(1, 8'h31, 64'd11, 64'd12, 64'd13);
        req_on(3, 8'h33, 64'd31, 64'd32, 64'd33);
        grant_step("rr_1a", 4'b0010, 0, 1);
        grant_step("rr_3a", 4'b1000, 1, 3);
        done(0, 64'hC1);
        done(1, 64'hC3);
        expect_resp(1, 1'b0, 64'hC1, cyc + 1);
        expect_resp(3, 1'b0, 64'hC3, cyc + 1);
        grant_step("rr_busy", 4'b0000, 0, 0);
        bus.core_done = '0;
        grant_step("rr_1b", 4'b0010, 0, 1);
        grant_step("rr_3b", 4'b1000, 1, 3);
        req_off(1);
        req_off(3);
        done(0, 64'hD1);
        done(1, 64'hD3);
        expect_resp(1, 1'b0, 64'hD1, cyc + 1);
        expect_resp(3, 1'b0, 64'hD3, cyc + 1);
        tick();
        bus.core_done = '0;
        tick();

        // Watchdog expiry, then reuse with done landing in the expiry cycle.
        req_on(0, 8'h40, 64'd1, 64'd2, 64'd3);
        grant_step("wd_grant", 4'b0001, 0, 0);
        req_off(0);
        abort_q.push_back('{0, cyc + TO});
        expect_resp(0, 1'b1, 64'h0, cyc + TO);
        tick(TO + 2);
        req_on(1, 8'h41, 64'd7, 64'd8, 64'd9);
        grant_step("wd_reuse", 4'b0010, 0, 1);
        req_off(1);
        tick(TO - 1);
        done(0, 64'h55);
        expect_resp(1, 1'b0, 64'h55, cyc + 1);
        tick();
        bus.core_done = '0;
        tick(2);

        // Single outstanding: requester 2 holds valid while core 1 sits idle.
        req_on(2, 8'h50, 64'd21, 64'd22, 64'd23);
        grant_step("so_grant", 4'b0100, 0, 2);
        grant_step("so_hold0", 4'b0000, 0, 0);
        grant_step("so_hold1", 4'b0000, 0, 0);
        grant_step("so_hold2", 4'b0000, 0, 0);
        done(0, 64'h77);
        expect_resp(2, 1'b0, 64'h77, cyc + 1);
        grant_step("so_done_cyc", 4'b0000, 0, 0);
        bus.core_done = '0;
        grant_step("so_regrant", 4'b0100, 0, 2);
        req_off(2);
        done(0, 64'h78);
        expect_resp(2, 1'b0, 64'h78, cyc + 1);
        tick();
        bus.core_done = '0;
        tick();

        // Reset while both cores are busy; late dones must be ignored.
        req_on(0, 8'h60, 64'd61, 64'd62, 64'd63);
        req_on(1, 8'h61, 64'd71, 64'd72, 64'd73);
        grant_step("rm_g0", 4'b0001, 0, 0);
        req_off(0);
        grant_step("rm_g1", 4'b0010, 1, 1);
        req_off(1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rm_req_ready", bus.req_ready, 0);
        chk("rm_resp_valid", bus.resp_valid, 0);
        chk("rm_core_start", bus.core_start, 0);
        chk("rm_core_abort", bus.core_abort, 0);
        chk("rm_core_fid", bus.core_fid, 0);
        chk("rm_core_args", bus.core_args, 0);
        @(posedge clk);
        #1;
        done(0, 64'hEE);
        done(1, 64'hEF);
        tick();
        bus.core_done = '0;
        tick(3);
        req_on(2, 8'h62, 64'd81, 64'd82, 64'd83);
        grant_step("rm_new", 4'b0100, 0, 2);
        req_off(2);
        done(0, 64'h99);
        expect_resp(2, 1'b0, 64'h99, cyc + 1);
        tick();
        bus.core_done = '0;
        tick(TO + 4);

        chk("resp_q_empty", resp_q.size(), 0);
        chk("start_q_empty", start_q.size(), 0);
        chk("abort_q_empty", abort_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
